// File: rtl/load_lsu.sv
// Byte-banked load unit: splits a byte/half/word load across four 8-bit banks
// and returns the sign/zero-extended result. Define LOAD_LSU_MISALIGN_TRAP_EN to flag misaligned loads instead of servicing them.
module load_lsu (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_ld_req,
    output logic        o_ld_ready,
    input  logic [31:0] i_lsu_addr,
    input  logic [2:0]  i_bmask,
    input  logic        i_ld_unsigned,
    output logic [14:0] o_addr_even_1,
    output logic [14:0] o_addr_even_2,
    output logic [14:0] o_addr_odd_1,
    output logic [14:0] o_addr_odd_2,
    output logic        o_re_even_1,
    output logic        o_re_even_2,
    output logic        o_re_odd_1,
    output logic        o_re_odd_2,
    input  logic [7:0]  i_rdata_even_1,
    input  logic [7:0]  i_rdata_even_2,
    input  logic [7:0]  i_rdata_odd_1,
    input  logic [7:0]  i_rdata_odd_2,
    output logic [31:0] o_ld_data,
    output logic        o_ld_valid,
    input  logic        i_ld_ack,
    output logic        o_ld_misaligned
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;

    logic [15:0] addr_reg;
    logic [2:0]  bmask_reg;
    logic        unsigned_reg;

    logic [31:0] ld_data_reg;
    logic [31:0] ld_data_next;
    logic        ld_valid_reg;
    logic        ld_misaligned_reg;

    logic        accept;
    logic        read_active;
    logic        is_byte;
    logic        is_half;
    logic        is_word;
    logic        misalign_hit;
    logic [3:0]  lane_need;

    logic [14:0] idx_0;
    logic [14:0] idx_1;
    logic [14:0] idx_2;

    // Bank order everywhere below: 0 = even_1, 1 = odd_1, 2 = even_2, 3 = odd_2
    logic [14:0] bank_idx   [4];
    logic [7:0]  bank_rdata [4];
    logic [3:0]  bank_re;
    logic [7:0]  lane_byte  [4];

    logic        unused_addr_hi;
    assign unused_addr_hi = ^i_lsu_addr[31:16];

    assign o_ld_ready  = (state_reg == ST_IDLE);
    assign accept      = (state_reg == ST_IDLE) && i_ld_req;
    assign read_active = (state_reg == ST_READ);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_ld_req) state_next = ST_READ;
            ST_READ: state_next = ST_RESP;
            ST_RESP: if (i_ld_ack) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            addr_reg     <= '0;
            bmask_reg    <= '0;
            unsigned_reg <= 1'b0;
        end else if (accept) begin
            addr_reg     <= i_lsu_addr[15:0];
            bmask_reg    <= i_bmask;
            unsigned_reg <= i_ld_unsigned;
        end
    end

    assign is_byte = (bmask_reg == 3'b001);
    assign is_half = (bmask_reg == 3'b010);
    assign is_word = (bmask_reg == 3'b100);

`ifdef LOAD_LSU_MISALIGN_TRAP_EN
    assign misalign_hit = (is_half && addr_reg[0]) || (is_word && (addr_reg[1:0] != 2'b00));
`else
    assign misalign_hit = 1'b0;
`endif

    // Lanes are numbered by result byte position, not by bank
    always_comb begin
        lane_need = 4'b0000;
        if (!misalign_hit) begin
            if (is_byte)      lane_need = 4'b0001;
            else if (is_half) lane_need = 4'b0011;
            else if (is_word) lane_need = 4'b1111;
        end
    end

    assign idx_0 = addr_reg[15:1];
    assign idx_1 = idx_0 + 15'd1;
    assign idx_2 = idx_0 + 15'd2;

    assign bank_idx[0] = addr_reg[0] ? idx_1 : idx_0;
    assign bank_idx[1] = idx_0;
    assign bank_idx[2] = addr_reg[0] ? idx_2 : idx_1;
    assign bank_idx[3] = idx_1;

    assign bank_rdata[0] = i_rdata_even_1;
    assign bank_rdata[1] = i_rdata_odd_1;
    assign bank_rdata[2] = i_rdata_even_2;
    assign bank_rdata[3] = i_rdata_odd_2;

    // An odd start address swaps even/odd within each pair of banks
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam int PAIR = gi ^ 1;
            assign lane_byte[gi] = addr_reg[0] ? bank_rdata[PAIR] : bank_rdata[gi];
            assign bank_re[gi]   = read_active && (addr_reg[0] ? lane_need[PAIR] : lane_need[gi]);
        end
    endgenerate

    assign o_re_even_1 = bank_re[0];
    assign o_re_odd_1  = bank_re[1];
    assign o_re_even_2 = bank_re[2];
    assign o_re_odd_2  = bank_re[3];

    assign o_addr_even_1 = read_active ? bank_idx[0] : '0;
    assign o_addr_odd_1  = read_active ? bank_idx[1] : '0;
    assign o_addr_even_2 = read_active ? bank_idx[2] : '0;
    assign o_addr_odd_2  = read_active ? bank_idx[3] : '0;

    always_comb begin
        ld_data_next = '0;
        if (!misalign_hit) begin
            if (is_byte) begin
                ld_data_next = {{24{~unsigned_reg & lane_byte[0][7]}}, lane_byte[0]};
            end else if (is_half) begin
                ld_data_next = {{16{~unsigned_reg & lane_byte[1][7]}}, lane_byte[1], lane_byte[0]};
            end else if (is_word) begin
                ld_data_next = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
            end
        end
    end

    // Result is captured on the READ->RESP edge and held until acknowledged
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            ld_data_reg       <= '0;
            ld_valid_reg      <= 1'b0;
            ld_misaligned_reg <= 1'b0;
        end else if (read_active) begin
            ld_data_reg       <= ld_data_next;
            ld_valid_reg      <= 1'b1;
            ld_misaligned_reg <= misalign_hit;
        end else if ((state_reg == ST_RESP) && i_ld_ack) begin
            ld_valid_reg      <= 1'b0;
            ld_misaligned_reg <= 1'b0;
        end
    end

    assign o_ld_data       = ld_data_reg;
    assign o_ld_valid      = ld_valid_reg;
    assign o_ld_misaligned = ld_misaligned_reg;

endmodule
